imem_boot_loader: RTL
=====================

Name: imem_boot_loader

Overview:
Boot-time controller that sequences the single-cycle RV32 core. It holds the core in reset and accepts a little-endian byte stream over a valid/ready handshake. It packs the stream into 32-bit words, writes them to consecutive instruction-memory words starting at word 0, then releases the core. A watchdog aborts a stalled load and keeps the core in reset.

Parameters:
ADDR_W, 8, instruction-memory word-address width; capacity 2**ADDR_W words
TIMEOUT, 1000, max idle cycles between accepted bytes while loading, 1..65535

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-low reset (0 = reset)
start  input  1  single-cycle pulse; begin (re)load of len_words words
len_words  input  ADDR_W+1  number of words to load, sampled on start
byte_valid  input  1  byte_data valid
byte_data  input  8  stream byte, least-significant byte of each word first
byte_ready  output  1  loader accepts byte this cycle
imem_we  output  1  instruction-memory write strobe, one cycle per word
imem_addr  output  ADDR_W  word address for write
imem_wdata  output  32  packed word
cpu_rst  output  1  active-low reset to core; 0 holds core in reset
busy  output  1  high in LOAD or WRITE
done  output  1  high in RUN
err  output  1  high in ERROR

Behaviour:
- Reset (rst=0 at a clock edge):
  - state=IDLE; byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_rst=0, busy=0, done=0, err=0.
  - Byte counter, word counter and watchdog are cleared.
  - Reset mid-load discards any partial word and issues no write.
- States: IDLE, LOAD, WRITE, RUN, ERROR. All outputs are registered or decoded from the state register.
- IDLE, RUN or ERROR with start=1:
  - len_words==0 -> RUN.
  - len_words > 2**ADDR_W -> ERROR.
  - Otherwise -> LOAD: word counter=0, byte counter=0, watchdog=0, len_words latched.
  - start in LOAD or WRITE is ignored.
- LOAD:
  - byte_ready=1. A byte is accepted on an edge where byte_valid & byte_ready.
  - Byte k (k=0..3) goes to imem_wdata[8k+7:8k]. byte counter is 2 bits and wraps 3->0.
  - Accepting byte 3 -> WRITE.
  - Watchdog increments each LOAD cycle with no accepted byte and clears on acceptance. Reaching TIMEOUT -> ERROR.
- WRITE:
  - Exactly one cycle: byte_ready=0, imem_we=1, imem_addr=word counter, imem_wdata=packed word.
  - Next edge: word counter+1.
  - If the incremented count == latched len_words -> RUN, else -> LOAD.
  - imem_addr holds the last written address after the write.
- RUN: cpu_rst=1, done=1. The core runs.
- Reload from RUN: start returns to LOAD and cpu_rst drops to 0 on the same edge the state changes.
- ERROR: err=1, cpu_rst=0. The partial load is abandoned; already-written words are not reverted.
- Load latency: from start edge to cpu_rst=1 is at least 5*N+1 cycles for N words with back-to-back valid bytes (4 LOAD + 1 WRITE per word, plus the start edge).
- cpu_rst is 0 in every state except RUN.
- byte_ready is 1 only in LOAD.
- imem_we is 1 only in WRITE.

Test Plan:
- rst=0 for 2 cycles with byte_valid=1 and start=1 -> all outputs 0, no imem_we pulse, state IDLE after rst=1.
- start, len_words=2, bytes 13,00,50,00,93,00,10,00 back-to-back -> imem_we at addr 0 data 0x00500013, then addr 1 data 0x00100093. cpu_rst=1 and done=1 exactly 11 cycles after the start edge.
- Same load with byte_valid deasserted for 3 cycles between bytes 1 and 2 -> identical writes; byte_ready stays 1 and watchdog clears. Then 1000 idle cycles mid-word -> err=1, cpu_rst=0, no further imem_we.
- In RUN, pulse start with len_words=1, bytes EF,BE,AD,DE -> cpu_rst falls on the start edge; addr 0 data 0xDEADBEEF; back to RUN.
- start with len_words=0 -> RUN next cycle, no writes. start with len_words=257 (ADDR_W=8) -> ERROR next cycle. len_words=256 -> 256 writes, last at addr 255, then RUN.
- rst=0 after byte 2 of word 1 -> no write for the partial word. Restart with len_words=1 writes addr 0.

Source files
------------

// File: rtl/imem_boot_loader.sv
// imem_boot_loader
//   Boot-time sequencer for the single-cycle RV32 core. It holds the core in
//   reset, packs a little-endian byte stream into 32-bit words, and writes
//   them to consecutive instruction-memory words starting at word 0. When the
//   requested number of words is in, it releases the core. A watchdog aborts
//   a stalled load and keeps the core in reset.
//
// Ports
//   clk, rst          clock / synchronous active-low reset
//   start, len_words  (re)load request and word count (sampled on start)
//   byte_valid/data   input byte stream, LSB of each word first
//   byte_ready        byte accepted on this edge when byte_valid is also high
//   imem_we/addr/wdata  one-cycle instruction-memory write per word
//   cpu_rst           active-low core reset (1 only in RUN)
//   busy/done/err     LOAD|WRITE / RUN / ERROR status
module imem_boot_loader #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   len_words,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WRITE, S_RUN, S_ERROR} state_t;

  // Memory capacity in words; len_words is one bit wider so it can hold it.
  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_W   = {{ADDR_W{1'b0}}, 1'b1};
  // The watchdog fires on the idle cycle that would bring it to TIMEOUT.
  localparam logic [15:0]     WD_LAST = 16'(TIMEOUT - 1);

  state_t            r_state, w_next;
  logic [ADDR_W:0]   r_wcnt, r_len, w_wcnt_inc;
  logic [1:0]        r_bcnt;
  logic [15:0]       r_wdog;
  logic [31:0]       r_word;
  logic [ADDR_W-1:0] r_addr;
  logic              w_accept, w_can_start, w_go;

  assign w_accept    = (r_state == S_LOAD) && byte_valid;
  assign w_wcnt_inc  = r_wcnt + ONE_W;
  assign w_can_start = (r_state == S_IDLE) || (r_state == S_RUN) || (r_state == S_ERROR);
  assign w_go        = w_can_start && start && (len_words != '0) && (len_words <= MAX_LEN);

  // State register
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_RUN, S_ERROR: begin
        if (start) begin
          if (len_words == '0)         w_next = S_RUN;
          else if (len_words > MAX_LEN) w_next = S_ERROR;
          else                          w_next = S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_accept && (r_bcnt == 2'd3))       w_next = S_WRITE;
        else if (!w_accept && (r_wdog == WD_LAST)) w_next = S_ERROR;
      end
      S_WRITE: w_next = (w_wcnt_inc == r_len) ? S_RUN : S_LOAD;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs decoded from the state register
  always_comb begin
    byte_ready = (r_state == S_LOAD);
    imem_we    = (r_state == S_WRITE);
    cpu_rst    = (r_state == S_RUN);
    busy       = (r_state == S_LOAD) || (r_state == S_WRITE);
    done       = (r_state == S_RUN);
    err        = (r_state == S_ERROR);
  end

  assign imem_addr  = r_addr;
  assign imem_wdata = r_word;

  // Datapath: byte packing, counters, watchdog
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wcnt <= '0;
      r_len  <= '0;
      r_bcnt <= '0;
      r_wdog <= '0;
      r_word <= '0;
      r_addr <= '0;
    end else if (w_go) begin
      r_wcnt <= '0;
      r_bcnt <= '0;
      r_wdog <= '0;
      r_len  <= len_words;
    end else if (r_state == S_LOAD) begin
      if (w_accept) begin
        r_word[{r_bcnt, 3'b000} +: 8] <= byte_data;
        r_bcnt <= r_bcnt + 2'd1;
        r_wdog <= '0;
        // Address is captured as the last byte lands so it is valid
        // during WRITE and keeps showing the last written word afterwards.
        if (r_bcnt == 2'd3) r_addr <= r_wcnt[ADDR_W-1:0];
      end else begin
        r_wdog <= r_wdog + 16'd1;
      end
    end else if (r_state == S_WRITE) begin
      r_wcnt <= w_wcnt_inc;
    end
  end

endmodule
